// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit teaching CPU and its program feeder:
// opcode field values, feeder state encoding and default sizing.
package cpu16_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int WDOG_DEF  = 8;

  // Opcode field is din[8:6]
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_IMM   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } feeder_state_e;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[8:6];
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x 16 words, synchronous write, asynchronous read.
// Contents are intentionally not reset so a program survives a feeder reset.
module prog_mem
  import cpu16_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [4:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < 6'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < 6'(DEPTH)) ? mem[raddr] : 16'h0000;

endmodule

// File: rtl/prog_feeder.sv
// Feeds a stored program word-by-word to the CPU, pacing on cpu_done,
// with a watchdog on each instruction and a sticky fault flag.
//
//   state | meaning
//   IDLE  | CPU held in reset, program may be loaded, waiting for start
//   ISSUE | CPU loads IR from din = mem[pc] (one cycle)
//   IMM   | mvi immediate word on din, waiting for cpu_done
//   EXEC  | non-mvi instruction executing, waiting for cpu_done
//   HALT  | program ended or faulted; pc/err held, CPU held in reset
module prog_feeder
  import cpu16_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WDOG  = WDOG_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [5:0]  prog_len,
  input  logic        start,
  input  logic        cpu_done,
  output logic [15:0] din,
  output logic        cpu_run,
  output logic        cpu_resetn,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  localparam int WDW = $clog2(WDOG + 1);

  feeder_state_e  state, state_nxt;
  logic [4:0]     pc_nxt;
  logic           err_nxt;
  logic [WDW-1:0] wd_cnt, wd_nxt;
  logic [15:0]    word;
  logic           mem_we, len_ok, at_last;

  assign mem_we = wr_en && (state == ST_IDLE || state == ST_HALT);

  prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (word)
  );

  assign len_ok  = (prog_len != 6'd0) && (prog_len <= 6'(DEPTH));
  // 6-bit compare so pc+1 == 32 matches prog_len == 32 without wrapping
  assign at_last = (({1'b0, pc} + 6'd1) == prog_len);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      pc     <= '0;
      err    <= 1'b0;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      err    <= err_nxt;
      wd_cnt <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = err;
    wd_nxt    = wd_cnt;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          if (len_ok) begin
            pc_nxt    = '0;
            err_nxt   = 1'b0;
            state_nxt = ST_ISSUE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_HALT;
          end
        end
      end
      ST_ISSUE: begin
        wd_nxt = '0;
        if (opcode_of(word) == OP_MVI) begin
          if (at_last) begin
            err_nxt   = 1'b1;
            state_nxt = ST_HALT;
          end else begin
            pc_nxt    = pc + 5'd1;
            state_nxt = ST_IMM;
          end
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_IMM, ST_EXEC: begin
        wd_nxt = wd_cnt + 1'b1;
        if (cpu_done) begin
          if (at_last) begin
            state_nxt = ST_HALT;
          end else begin
            pc_nxt    = pc + 5'd1;
            state_nxt = ST_ISSUE;
          end
        end else if (wd_cnt == WDW'(WDOG - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state == ST_ISSUE) || (state == ST_IMM) || (state == ST_EXEC);
  assign halted     = (state == ST_HALT);
  assign cpu_run    = busy;
  assign cpu_resetn = busy;
  assign din        = (state == ST_ISSUE || state == ST_IMM) ? word : 16'h0000;

endmodule

// File: tb/tb_prog_feeder.sv
// Bench for prog_feeder: a program-walk model builds the expected per-cycle
// trace (and the cpu_done pacing) for each run; a negedge process compares.
module tb_prog_feeder;

  localparam int DEPTH = 32;
  localparam int WDOG  = 8;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_IMM = 2, P_EXEC = 3, P_HALT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [5:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        cpu_done = 1'b0;
  logic [15:0] din;
  logic        cpu_run, cpu_resetn, busy, halted, err;
  logic [4:0]  pc;

  prog_feeder #(.DEPTH(DEPTH), .WDOG(WDOG)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .prog_len(prog_len), .start(start),
    .cpu_done(cpu_done), .din(din), .cpu_run(cpu_run),
    .cpu_resetn(cpu_resetn), .pc(pc), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ph;
    logic [4:0]  pc;
    logic        err;
    logic [15:0] din;
    logic        done;
  } rec_t;

  typedef struct {
    string nm;
    int    got;
    int    want;
  } pin_t;

  rec_t        exp_q[$];
  rec_t        exp_r;
  pin_t        pin_q[$];
  bit          chk_en = 1'b0;
  bit          noise_en = 1'b0;
  logic [15:0] m_mem [DEPTH];
  logic [4:0]  m_pc = '0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic rec_t mk(int ph, int p, logic e, logic d);
    rec_t r;
    r.ph   = ph;
    r.pc   = 5'(p);
    r.err  = e;
    r.done = d;
    r.din  = (ph == P_ISSUE || ph == P_IMM) ? m_mem[5'(p)] : 16'h0000;
    return r;
  endfunction

  // mode 0: random pacing (occasional timeout); 1: CPU-like (mv/mvi 1 cycle,
  // add/sub 3 cycles); 2: cpu_done never arrives
  function automatic int lat_for(int mode, logic [15:0] w, bit is_imm);
    if (mode == 2) return WDOG + 1;
    if (mode == 1) return (is_imm || w[8:7] == 2'b00) ? 1 : 3;
    if ($urandom_range(0, 9) == 0) return WDOG + 1;
    return int'($urandom_range(1, WDOG));
  endfunction

  task automatic gen_trace(input int len, input int mode);
    int p, lat, ph;
    logic [15:0] w;
    bit fin;
    exp_q.delete();
    if (len == 0 || len > DEPTH) begin
      exp_q.push_back(mk(P_HALT, int'(m_pc), 1'b1, 1'b0));
      return;
    end
    p = 0;
    fin = 1'b0;
    while (!fin) begin
      w = m_mem[5'(p)];
      exp_q.push_back(mk(P_ISSUE, p, 1'b0, (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0));
      if (w[8:6] == 3'b001 && p == len - 1) begin
        exp_q.push_back(mk(P_HALT, p, 1'b1, 1'b0));
        fin = 1'b1;
      end else begin
        if (w[8:6] == 3'b001) begin
          p++;
          ph  = P_IMM;
          lat = lat_for(mode, w, 1'b1);
        end else begin
          ph  = P_EXEC;
          lat = lat_for(mode, w, 1'b0);
        end
        for (int k = 1; k <= WDOG && k <= lat; k++)
          exp_q.push_back(mk(ph, p, 1'b0, k == lat));
        if (lat > WDOG) begin
          exp_q.push_back(mk(P_HALT, p, 1'b1, 1'b0));
          fin = 1'b1;
        end else if (p + 1 == len) begin
          exp_q.push_back(mk(P_HALT, p, 1'b0, 1'b0));
          fin = 1'b1;
        end else begin
          p++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int got, input int want);
    pin_t t;
    t.nm = nm;
    t.got = got;
    t.want = want;
    pin_q.push_back(t);
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    m_mem[5'(a)] = d;
    wr_en = 1'b0;
  endtask

  task automatic run(input int len, input int mode, input bit w0_with_start, input logic [15:0] w0);
    if (w0_with_start) begin
      wr_en = 1'b1;
      wr_addr = 5'd0;
      wr_data = w0;
      m_mem[0] = w0;
    end
    prog_len = 6'(len);
    start = 1'b1;
    gen_trace(len, mode);
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    foreach (exp_q[i]) begin
      exp_r = exp_q[i];
      cpu_done = exp_r.done;
      if (noise_en && exp_r.ph >= P_ISSUE && exp_r.ph <= P_EXEC) begin
        wr_en   = 1'($urandom_range(0, 1));
        wr_addr = 5'($urandom_range(0, 7));
        wr_data = 16'($urandom);
        start   = 1'($urandom_range(0, 1));
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      tick();
    end
    cpu_done = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    m_pc = exp_r.pc;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    w[8:6] = 3'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    pin_t t;
    bit b;
    if (chk_en) begin
      b = (exp_r.ph == P_ISSUE || exp_r.ph == P_IMM || exp_r.ph == P_EXEC);
      chk("busy", int'(busy), int'(b));
      chk("halted", int'(halted), int'(exp_r.ph == P_HALT));
      chk("cpu_run", int'(cpu_run), int'(b));
      chk("cpu_resetn", int'(cpu_resetn), int'(b));
      chk("err", int'(err), int'(exp_r.err));
      chk("pc", int'(pc), int'(exp_r.pc));
      chk("din", int'(din), int'(exp_r.din));
    end
    while (pin_q.size() > 0) begin
      t = pin_q.pop_front();
      chk(t.nm, t.got, t.want);
    end
  end

  initial begin
    int n_exec;
    int lit_ph[9] = '{1, 2, 1, 3, 1, 3, 3, 3, 4};
    exp_r = mk(P_IDLE, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(i, rand_word());

    // reference program: mvi/imm, mv, add
    write_word(0, 16'h0040);
    write_word(1, 16'h0005);
    write_word(2, 16'h0008);
    write_word(3, 16'h0081);
    run(4, 1, 1'b0, 16'h0);
    pin("ref_len", exp_q.size(), 9);
    foreach (lit_ph[i]) pin("ref_phase", (i < exp_q.size()) ? exp_q[i].ph : -1, lit_ph[i]);
    pin("ref_halted", int'(halted), 1);
    pin("ref_pc", int'(pc), 3);
    pin("ref_err", int'(err), 0);
    tick();

    // watchdog
    write_word(0, 16'h0081);
    run(1, 2, 1'b0, 16'h0);
    n_exec = 0;
    foreach (exp_q[i]) if (exp_q[i].ph == P_EXEC) n_exec++;
    pin("wdog_exec_cycles", n_exec, WDOG);
    pin("wdog_err", int'(err), 1);
    tick();
    tick();

    // mvi with no immediate
    write_word(0, 16'h0040);
    run(1, 0, 1'b0, 16'h0);
    pin("mvi_last_len", exp_q.size(), 2);
    pin("mvi_last_err", int'(err), 1);

    // empty program
    run(0, 0, 1'b0, 16'h0);
    pin("len0_len", exp_q.size(), 1);
    pin("len0_halted", int'(halted), 1);

    // reset during EXEC of an add, then rerun
    write_word(0, 16'h0081);
    prog_len = 6'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_r = mk(P_ISSUE, 0, 1'b0, 1'b0);
    tick();
    exp_r = mk(P_EXEC, 0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_r = mk(P_IDLE, 0, 1'b0, 1'b0);
    m_pc = '0;
    tick();
    run(1, 1, 1'b0, 16'h0);

    // randomized programs with busy-time write/start noise
    noise_en = 1'b1;
    for (int it = 0; it < 60; it++) begin
      int len, sel;
      for (int j = 0; j < int'($urandom_range(0, 4)); j++)
        write_word(int'($urandom_range(0, 9)), rand_word());
      sel = int'($urandom_range(0, 19));
      if (sel == 0) len = 0;
      else if (sel == 1) len = int'($urandom_range(DEPTH + 1, 63));
      else if (sel == 2) len = DEPTH;
      else len = int'($urandom_range(1, 10));
      run(len, 0, 1'($urandom_range(0, 1)), rand_word());
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
    end

    tick();
    tick();
    chk_en = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_feeder.md
PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 16-bit program words held.
REQ-002 SHALL have parameter WDOG, default 8, meaning the maximum number of cycles to wait for cpu_done before faulting.
REQ-003 SHALL have ports as follows; reset resetn, synchronous, active-low; clock clk.
  clk  in  1  clock, rising edge
  resetn  in  1  synchronous active-low reset
  wr_en  in  1  program-load write strobe
  wr_addr  in  5  program-load word address
  wr_data  in  16  program-load word
  prog_len  in  6  words in program, 1..DEPTH
  start  in  1  run request, sampled per cycle
  cpu_done  in  1  CPU instruction-complete flag
  din  out  16  instruction/immediate word to CPU
  cpu_run  out  1  CPU run enable
  cpu_resetn  out  1  CPU reset, active-low
  pc  out  5  current word address
  busy  out  1  high in ISSUE/IMM/EXEC
  halted  out  1  high in HALT
  err  out  1  sticky fault flag

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, IMM, EXEC and HALT.
REQ-005 IDLE/HALT: start=1 with prog_len in 1..DEPTH SHALL set pc<=0, clear err, and go to ISSUE; start with prog_len=0 or prog_len>DEPTH SHALL set err and go to HALT.
REQ-006 ISSUE SHALL last 1 cycle (CPU in state_0, loading IR): if din[8:6]=001 (mvi), go to IMM; otherwise go to EXEC.
REQ-007 ISSUE SHALL do pc<=pc+1 when entering IMM; otherwise pc is unchanged.
REQ-008 ISSUE SHALL treat an mvi at pc=prog_len-1 as a missing immediate: set err, go to HALT.
REQ-009 IMM and EXEC SHALL wait for cpu_done=1.
REQ-010 On cpu_done in IMM/EXEC: if pc+1 (6-bit compare) = prog_len, go to HALT; else pc<=pc+1 and go to ISSUE.
REQ-011 SHALL count cycles spent in IMM/EXEC, with the counter cleared on entering either state.
REQ-012 When WDOG cycles elapse without cpu_done, SHALL set err and go to HALT.
REQ-013 din SHALL equal mem[pc] (asynchronous read) in ISSUE/IMM, and 16'h0000 otherwise.
REQ-014 cpu_run SHALL be 1 in ISSUE/IMM/EXEC, and 0 otherwise.
REQ-015 cpu_resetn SHALL be 0 in IDLE/HALT, and 1 otherwise, so the CPU step counter is at state_0 on the first ISSUE.
REQ-016 Program writes SHALL be accepted only in IDLE/HALT; wr_en while busy SHALL be ignored.
REQ-017 wr_en and start in the same cycle SHALL commit the write and accept start, and the first ISSUE SHALL read the new word.
REQ-018 start while busy SHALL be ignored.
REQ-019 HALT SHALL hold pc, halted=1 and err until the next accepted start or reset.
REQ-020 pc SHALL never exceed DEPTH-1 and SHALL not wrap.

Reset
REQ-021 On resetn=0 at a clock edge, state SHALL be IDLE, pc=0, err=0, the watchdog counter=0, din=0, cpu_run=0, cpu_resetn=0, busy=0 and halted=0.
REQ-022 Reset mid-program SHALL abort immediately with no further CPU words issued.
REQ-023 Program memory SHALL not be reset.

Structure
REQ-024 Shared package cpu16_pkg SHALL hold opcode constants MV=000, MVI=001, ADD=010, SUB=011.
REQ-025 cpu16_pkg SHALL hold the feeder state encoding and the DEPTH/WDOG defaults.
REQ-026 Storage SHALL be sub-module prog_mem: DEPTH x 16, synchronous write, asynchronous read.

Verification
REQ-027 Load 0x0040, 0x0005, 0x0008, 0x0081, prog_len=4, start at edge E0 with the feeder driving the CPU -> ISSUE, IMM, ISSUE, EXEC, ISSUE, EXEC x3; halted=1 after E8; CPU r0=10, r1=5; err=0.
REQ-028 cpu_done tied 0, program 0x0081, prog_len=1 -> err=1 and halted=1 exactly WDOG cycles after EXEC entry; cpu_run=0 thereafter.
REQ-029 Program 0x0040 alone, prog_len=1 -> after the ISSUE cycle, err=1 and halted=1; no IMM cycle.
REQ-030 wr_en to addr 3 during busy -> mem[3] unchanged; start pulse during busy -> no restart; pc sequence unaffected.
REQ-031 resetn=0 in EXEC of an add -> next cycle: IDLE, cpu_resetn=0, din=0, pc=0; a later start reruns from word 0.
REQ-032 prog_len=0, start -> err=1, halted=1, and cpu_run never asserted.
